warp_instr_buffer: RTL and testbench
====================================

Name: warp_instr_buffer

Overview:
- Per-warp instruction buffer between the decoder and the dispatch/issue stage.
- Reserves a slot when the fetcher hands a PC to the I-cache. Stores the decoded instruction and presents each warp's oldest instruction for dispatch.
- Tracks dispatched-but-unretired instructions.
- Produces the per-warp "space available" and "all instructions finished" vectors consumed by the fetcher.

Parameters:
- NumWarps, 8, warps per compute unit.
- Depth, 4, instruction slots per warp (power of two, >=2).
- MaxInflight, 7, max dispatched-not-retired instructions per warp.
- InstrWidth, 64, width of decoded instruction payload.
- WidWidth, derived: NumWarps>1 ? $clog2(NumWarps) : 1; do not override.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- fe_fetch_i  in  1  fetcher PC accepted by I-cache this cycle (valid&ready)
- fe_warp_id_i  in  WidWidth  warp of accepted fetch
- dec_valid_i  in  1  decoder result for a previously fetched instruction
- dec_write_i  in  1  1: store dec_instr_i; 0: drop (reservation freed only)
- dec_warp_id_i  in  WidWidth  warp of decoder result
- dec_instr_i  in  InstrWidth  decoded instruction
- ib_space_available_o  out  NumWarps  warp may issue another fetch
- ib_all_instr_finished_o  out  NumWarps  warp has nothing reserved, buffered or in flight
- ib_valid_o  out  NumWarps  head instruction of warp available for dispatch
- ib_instr_o  out  NumWarps*InstrWidth  head instruction per warp
- disp_pop_i  in  NumWarps  dispatch consumes head of warp
- retire_i  in  1  one instruction completed
- retire_warp_id_i  in  WidWidth  warp of retired instruction

Behaviour:
- Interface: single clock clk_i; reset rst_ni asynchronous, active-low.
- Per-warp state:
  - Circular FIFO of Depth entries with rd/wr pointers.
  - Counters `reserved`, `occ` (0..Depth, $clog2(Depth+1) bits).
  - Counter `inflight` (0..MaxInflight, $clog2(MaxInflight+1) bits).
- Reset:
  - All counters and pointers 0; FIFO contents not reset.
  - ib_space_available_o = all 1.
  - ib_all_instr_finished_o = all 1.
  - ib_valid_o = 0.
- ib_space_available_o[w] = (occ+reserved) < Depth. Combinational from registers; no input-to-output path.
- ib_valid_o[w] = occ!=0 && inflight<MaxInflight. ib_instr_o[w] = FIFO[rd_ptr]. Both registered-state driven, no bypass.
- ib_all_instr_finished_o[w] = reserved==0 && occ==0 && inflight==0.
- Fetch: fe_fetch_i -> reserved[fe_warp_id_i]+1 next cycle. Effect appears one cycle after the handshake, so the fetcher sees space drop with latency 1. Same-cycle re-fetch of the same warp is therefore possible; space is computed as (occ+reserved) and fetcher-side locking prevents double fetch.
- Decode:
  - dec_valid_i -> reserved[w]-1.
  - If dec_write_i: FIFO[wr_ptr]<=dec_instr_i, wr_ptr+1 (wraps mod Depth), occ+1.
  - Instruction visible on ib_valid_o the next cycle (write-to-read latency 1).
- Pop: disp_pop_i[w] is honoured only when ib_valid_o[w]=1 (otherwise ignored). Then rd_ptr+1 (wrap), occ-1, inflight+1.
- Retire: retire_i -> inflight[retire_warp_id_i]-1.
- Simultaneous events on one warp: all apply in the same cycle.
  - Net counter change = sum of increments/decrements. Example: fetch+decode-drop on the same warp leaves reserved unchanged.
  - Push and pop on the same warp with occ==Depth-... is legal. Pop reads the old head; push writes the tail. Pop on an empty FIFO is impossible because of the ib_valid gating.
  - Pop and retire same cycle with inflight==MaxInflight: pop is blocked (gated by registered inflight) and the retire applies.
- Illegal events (flag with $error under `ifndef SYNTHESIS`; RTL behaviour undefined):
  - decode with reserved==0
  - fetch with occ+reserved==Depth
  - retire with inflight==0
  - push with occ==Depth
- Reset mid-operation: all state cleared immediately (asynchronous). Outstanding I-cache responses must not arrive after reset; the enclosing unit flushes them.

Test Plan:
- Reset -> space=all 1, finished=all 1, ib_valid=0; one fetch on warp 2 -> next cycle finished[2]=0, space[2]=1.
- Warp 0: 4 fetches (Depth=4) -> space[0]=0 after 4th. Then 4 decode writes with instr 0x11..0x44 -> ib_valid[0]=1, head 0x11. 4 pops -> heads 0x11,0x22,0x33,0x44 in order; pointer wrap verified on a second pass.
- Decode drop (dec_write_i=0) on warp 3 after one fetch -> reserved back to 0, ib_valid[3]=0, finished[3]=1.
- Warp 1: 7 pops without retire (MaxInflight=7) -> ib_valid[1]=0 with occ>0. One retire -> ib_valid[1]=1 next cycle.
- Same cycle on warp 5: fetch + decode write + pop + retire -> reserved, occ, inflight unchanged; wr_ptr/rd_ptr each advance 1; popped value = old head.
- Assert rst_ni low mid-traffic across several warps -> all outputs return to reset values asynchronously. After release, a fetch/decode/pop/retire sequence on warp 7 ends with finished[7]=1.

Source files
------------

// File: rtl/warp_instr_buffer_if.sv
// Fetch/decode/dispatch/retire bundle between the warp instruction buffer and its neighbours.
// The buffer side uses the slave modport; the surrounding front end uses master.
interface warp_instr_buffer_if #(
    parameter int NumWarps   = 8,
    parameter int InstrWidth = 64
);
    localparam int WidWidth = (NumWarps > 1) ? $clog2(NumWarps) : 1;

    logic                                 fe_fetch_i;
    logic [WidWidth-1:0]                  fe_warp_id_i;
    logic                                 dec_valid_i;
    logic                                 dec_write_i;
    logic [WidWidth-1:0]                  dec_warp_id_i;
    logic [InstrWidth-1:0]                dec_instr_i;
    logic [NumWarps-1:0]                  ib_space_available_o;
    logic [NumWarps-1:0]                  ib_all_instr_finished_o;
    logic [NumWarps-1:0]                  ib_valid_o;
    logic [NumWarps-1:0][InstrWidth-1:0]  ib_instr_o;
    logic [NumWarps-1:0]                  disp_pop_i;
    logic                                 retire_i;
    logic [WidWidth-1:0]                  retire_warp_id_i;

    modport slave (
        input  fe_fetch_i, fe_warp_id_i, dec_valid_i, dec_write_i, dec_warp_id_i,
               dec_instr_i, disp_pop_i, retire_i, retire_warp_id_i,
        output ib_space_available_o, ib_all_instr_finished_o, ib_valid_o, ib_instr_o
    );

    modport master (
        output fe_fetch_i, fe_warp_id_i, dec_valid_i, dec_write_i, dec_warp_id_i,
               dec_instr_i, disp_pop_i, retire_i, retire_warp_id_i,
        input  ib_space_available_o, ib_all_instr_finished_o, ib_valid_o, ib_instr_o
    );
endinterface

// File: rtl/warp_instr_buffer.sv
// Per-warp instruction buffer: slot reservation at fetch, decoded-instruction FIFO,
// head presentation for dispatch and dispatched-but-unretired tracking.
module warp_ib_lane #(
    parameter int Lane        = 0,
    parameter int Depth       = 4,
    parameter int MaxInflight = 7,
    parameter int InstrWidth  = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  fetch_i,
    input  logic                  dec_valid_i,
    input  logic                  dec_write_i,
    input  logic [InstrWidth-1:0] dec_instr_i,
    input  logic                  pop_i,
    input  logic                  retire_i,
    output logic                  space_o,
    output logic                  finished_o,
    output logic                  valid_o,
    output logic [InstrWidth-1:0] instr_o
);
    localparam int PtrW = $clog2(Depth);
    localparam int OccW = $clog2(Depth + 1);
    localparam int InfW = $clog2(MaxInflight + 1);

    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [OccW-1:0]       reserved_q, reserved_d, occ_q, occ_d;
    logic [InfW-1:0]       inflight_q, inflight_d;
    logic [InstrWidth-1:0] mem_q [Depth];
    logic                  push, pop_ok;

    assign push   = dec_valid_i & dec_write_i;
    // Pop is gated by registered state only, so a same-cycle retire cannot unblock it.
    assign pop_ok = pop_i & valid_o;

    assign space_o    = ({1'b0, occ_q} + {1'b0, reserved_q}) < (OccW+1)'(Depth);
    assign valid_o    = (occ_q != '0) && (inflight_q < InfW'(MaxInflight));
    assign finished_o = (reserved_q == '0) && (occ_q == '0) && (inflight_q == '0);
    assign instr_o    = mem_q[rd_ptr_q];

    always_comb begin
        reserved_d = reserved_q + OccW'(fetch_i) - OccW'(dec_valid_i);
        occ_d      = occ_q + OccW'(push) - OccW'(pop_ok);
        inflight_d = inflight_q + InfW'(pop_ok) - InfW'(retire_i);
        wr_ptr_d   = wr_ptr_q + PtrW'(push);
        rd_ptr_d   = rd_ptr_q + PtrW'(pop_ok);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reserved_q <= '0;
            occ_q      <= '0;
            inflight_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            reserved_q <= reserved_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Payload storage carries no reset; occ gates every read.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= dec_instr_i;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            if (dec_valid_i && reserved_q == '0)
                $error("warp %0d: decode with no reservation", Lane);
            if (fetch_i && !space_o)
                $error("warp %0d: fetch with buffer fully committed", Lane);
            if (retire_i && inflight_q == '0)
                $error("warp %0d: retire with nothing in flight", Lane);
            if (push && occ_q == OccW'(Depth))
                $error("warp %0d: push into full FIFO", Lane);
        end
    end
`endif
endmodule

module warp_instr_buffer #(
    parameter int NumWarps    = 8,
    parameter int Depth       = 4,
    parameter int MaxInflight = 7,
    parameter int InstrWidth  = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    warp_instr_buffer_if.slave   ib_if
);
    localparam int WidWidth = (NumWarps > 1) ? $clog2(NumWarps) : 1;

    logic [NumWarps-1:0]                 space_w, finished_w, valid_w;
    logic [NumWarps-1:0][InstrWidth-1:0] instr_w;

    for (genvar w = 0; w < NumWarps; w++) begin : g_lane
        warp_ib_lane #(
            .Lane        (w),
            .Depth       (Depth),
            .MaxInflight (MaxInflight),
            .InstrWidth  (InstrWidth)
        ) u_lane (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .fetch_i     (ib_if.fe_fetch_i  && (ib_if.fe_warp_id_i     == WidWidth'(w))),
            .dec_valid_i (ib_if.dec_valid_i && (ib_if.dec_warp_id_i    == WidWidth'(w))),
            .dec_write_i (ib_if.dec_write_i),
            .dec_instr_i (ib_if.dec_instr_i),
            .pop_i       (ib_if.disp_pop_i[w]),
            .retire_i    (ib_if.retire_i    && (ib_if.retire_warp_id_i == WidWidth'(w))),
            .space_o     (space_w[w]),
            .finished_o  (finished_w[w]),
            .valid_o     (valid_w[w]),
            .instr_o     (instr_w[w])
        );
    end

    assign ib_if.ib_space_available_o    = space_w;
    assign ib_if.ib_all_instr_finished_o = finished_w;
    assign ib_if.ib_valid_o              = valid_w;
    assign ib_if.ib_instr_o              = instr_w;
endmodule

// File: tb/tb_warp_instr_buffer.sv
// Directed bench for warp_instr_buffer: reservation, FIFO order/wrap, inflight limit,
// same-cycle event merging and asynchronous reset.
module tb_warp_instr_buffer;
    localparam int NW = 8;
    localparam int IW = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    warp_instr_buffer_if #(.NumWarps(NW), .InstrWidth(IW)) bus ();

    warp_instr_buffer #(.NumWarps(NW), .Depth(4), .MaxInflight(7), .InstrWidth(IW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .ib_if  (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        bus.fe_fetch_i       = 1'b0;
        bus.fe_warp_id_i     = '0;
        bus.dec_valid_i      = 1'b0;
        bus.dec_write_i      = 1'b0;
        bus.dec_warp_id_i    = '0;
        bus.dec_instr_i      = '0;
        bus.disp_pop_i       = '0;
        bus.retire_i         = 1'b0;
        bus.retire_warp_id_i = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic fetch(input int w);
        bus.fe_fetch_i = 1'b1; bus.fe_warp_id_i = 3'(w); step();
    endtask

    task automatic dec(input int w, input logic wr, input logic [63:0] ins);
        bus.dec_valid_i = 1'b1; bus.dec_write_i = wr;
        bus.dec_warp_id_i = 3'(w); bus.dec_instr_i = ins; step();
    endtask

    task automatic pop(input int w);
        bus.disp_pop_i = 8'(1 << w); step();
    endtask

    task automatic retire(input int w);
        bus.retire_i = 1'b1; bus.retire_warp_id_i = 3'(w); step();
    endtask

    initial begin
        clr();
        #2;
        chk("rst_space",    64'(bus.ib_space_available_o),    64'hFF);
        chk("rst_finished", 64'(bus.ib_all_instr_finished_o), 64'hFF);
        chk("rst_valid",    64'(bus.ib_valid_o),              64'h00);
        @(posedge clk); #1; rst_n = 1'b1;

        fetch(2);
        chk("w2_finished", 64'(bus.ib_all_instr_finished_o), 64'hFB);
        chk("w2_space",    64'(bus.ib_space_available_o[2]), 64'h1);

        // Warp 0: fill reservations, then FIFO, then drain in order
        for (int i = 0; i < 3; i++) fetch(0);
        chk("w0_space_3res", 64'(bus.ib_space_available_o[0]), 64'h1);
        fetch(0);
        chk("w0_space_full", 64'(bus.ib_space_available_o), 64'hFE);
        dec(0, 1'b1, 64'h11);
        chk("w0_valid_1", 64'(bus.ib_valid_o), 64'h01);
        chk("w0_head_1",  bus.ib_instr_o[0],   64'h11);
        dec(0, 1'b1, 64'h22); dec(0, 1'b1, 64'h33); dec(0, 1'b1, 64'h44);
        chk("w0_space_occ4", 64'(bus.ib_space_available_o[0]), 64'h0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("w0_head_pop%0d", i), bus.ib_instr_o[0], 64'(8'h11 * (i + 1)));
            pop(0);
        end
        chk("w0_valid_empty", 64'(bus.ib_valid_o[0]),           64'h0);
        chk("w0_space_empty", 64'(bus.ib_space_available_o[0]), 64'h1);
        fetch(0); fetch(0);
        dec(0, 1'b1, 64'h55); dec(0, 1'b1, 64'h66);
        chk("w0_wrap_head0", bus.ib_instr_o[0], 64'h55);
        pop(0);
        chk("w0_wrap_head1", bus.ib_instr_o[0], 64'h66);
        pop(0);
        chk("w0_busy", 64'(bus.ib_all_instr_finished_o[0]), 64'h0);
        for (int i = 0; i < 6; i++) retire(0);
        chk("w0_finished", 64'(bus.ib_all_instr_finished_o[0]), 64'h1);

        // Warp 3: reservation released by a dropped decode
        fetch(3);
        chk("w3_busy", 64'(bus.ib_all_instr_finished_o[3]), 64'h0);
        dec(3, 1'b0, 64'hDEAD);
        chk("w3_valid",    64'(bus.ib_valid_o[3]),              64'h0);
        chk("w3_finished", 64'(bus.ib_all_instr_finished_o[3]), 64'h1);

        // Warp 1: reach MaxInflight with an instruction still buffered
        for (int i = 0; i < 4; i++) fetch(1);
        for (int i = 0; i < 4; i++) dec(1, 1'b1, 64'hA0 + 64'(i));
        for (int i = 0; i < 4; i++) pop(1);
        for (int i = 0; i < 4; i++) fetch(1);
        for (int i = 0; i < 4; i++) dec(1, 1'b1, 64'hB0 + 64'(i));
        for (int i = 0; i < 3; i++) pop(1);
        chk("w1_blocked", 64'(bus.ib_valid_o[1]), 64'h0);
        chk("w1_head",    bus.ib_instr_o[1],      64'hB3);
        chk("w1_space",   64'(bus.ib_space_available_o[1]), 64'h1);
        pop(1);
        chk("w1_pop_ignored", bus.ib_instr_o[1], 64'hB3);
        retire(1);
        chk("w1_unblocked", 64'(bus.ib_valid_o[1]), 64'h1);

        // Warp 5: fetch + decode write + pop + retire in one cycle
        fetch(5); fetch(5); fetch(5);
        dec(5, 1'b1, 64'h500); dec(5, 1'b1, 64'h501);
        pop(5);
        chk("w5_head_before", bus.ib_instr_o[5], 64'h501);
        bus.fe_fetch_i = 1'b1;  bus.fe_warp_id_i = 3'd5;
        bus.dec_valid_i = 1'b1; bus.dec_write_i = 1'b1; bus.dec_warp_id_i = 3'd5;
        bus.dec_instr_i = 64'h502;
        bus.disp_pop_i = 8'h20;
        bus.retire_i = 1'b1;    bus.retire_warp_id_i = 3'd5;
        step();
        chk("w5_head_after", bus.ib_instr_o[5], 64'h502);
        chk("w5_valid",      64'(bus.ib_valid_o[5]), 64'h1);
        dec(5, 1'b1, 64'h503);
        chk("w5_space_occ2", 64'(bus.ib_space_available_o[5]), 64'h1);
        pop(5);
        chk("w5_head_next", bus.ib_instr_o[5], 64'h503);
        pop(5);
        chk("w5_empty", 64'(bus.ib_valid_o[5]), 64'h0);
        for (int i = 0; i < 3; i++) retire(5);
        chk("w5_finished", 64'(bus.ib_all_instr_finished_o[5]), 64'h1);

        // Asynchronous reset in the middle of a cycle with traffic pending
        fetch(6);
        bus.fe_fetch_i = 1'b1; bus.fe_warp_id_i = 3'd6;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_space",    64'(bus.ib_space_available_o),    64'hFF);
        chk("mid_rst_finished", 64'(bus.ib_all_instr_finished_o), 64'hFF);
        chk("mid_rst_valid",    64'(bus.ib_valid_o),              64'h00);
        clr();
        @(posedge clk); #1; rst_n = 1'b1;

        fetch(7);
        dec(7, 1'b1, 64'h777);
        chk("w7_valid", 64'(bus.ib_valid_o), 64'h80);
        chk("w7_head",  bus.ib_instr_o[7],   64'h777);
        pop(7);
        chk("w7_inflight", 64'(bus.ib_all_instr_finished_o[7]), 64'h0);
        retire(7);
        chk("w7_finished", 64'(bus.ib_all_instr_finished_o), 64'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
